alu_issue: RTL and testbench

Decode/issue stage that feeds the integer ALU, the producer end of the ALU's op/op_imm/funct3/funct7/a/b interface. Accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes OP/OP-IMM instructions. Reads operands from an internal 32x32 register file, blocks on RAW hazards via a busy scoreboard, and presents registered ALU controls and operands downstream. A writeback port returns results into the register file.

---
 rtl/alu_issue_pkg.sv | 42 ++++
 rtl/alu_issue_regfile_2r1w.sv | 42 ++++
 rtl/alu_issue.sv | 133 +++++++++++++
 tb/tb_alu_issue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared decode constants and the issue-entry layout for the ALU issue stage.
// Included by the issue top and its register file.
package alu_issue_pkg;

    localparam int NREG   = 32;
    localparam int XLEN   = 32;
    localparam int RIDX_W = $clog2(NREG);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SL   = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_funct3_e;

    typedef struct packed {
        logic              op;
        logic              op_imm;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [RIDX_W-1:0] rd;
        logic              illegal;
    } issue_t;

    // Shift-immediates carry a 5-bit shamt in the rs2 field, not a 12-bit immediate.
    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == ALU_SL) || (f3 == ALU_SR);
    endfunction

endpackage

// File: rtl/alu_issue_regfile_2r1w.sv
// Register file: two async reads, one sync write, x0 hardwired to zero.
// Latency: reads combinational; a same-cycle write is bypassed onto the read ports.
// Backpressure: none, writes are always accepted.
module regfile_2r1w #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic [AW-1:0]   rs1_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i
);

    logic [XLEN-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i != '0)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (wr_en_i && (wr_addr_i == addr)) begin
            val = wr_data_i;
        end else begin
            val = mem_q[addr];
        end
        return val;
    endfunction

    assign rs1_data_o = rd_port(rs1_addr_i);
    assign rs2_data_o = rd_port(rs2_addr_i);

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage for RV32I OP/OP-IMM into the integer ALU, with RAW scoreboard.
// Latency: 1 cycle accept-to-out_valid, one instruction per cycle without hazards.
// Backpressure: out_ready low holds the output entry; in_ready drops on hazard, full output or flush.
import alu_issue_pkg::*;

module alu_issue (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_op,
    output logic              out_op_imm,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [RIDX_W-1:0] out_rd,
    output logic              out_illegal,
    input  logic              wb_en,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [RIDX_W-1:0] rs1, rs2, rd;
    logic              is_op, is_imm, illegal;
    logic [XLEN-1:0]   rs1_val, rs2_val;

    assign opcode  = in_instr[6:0];
    assign rd      = in_instr[11:7];
    assign f3      = in_instr[14:12];
    assign rs1     = in_instr[19:15];
    assign rs2     = in_instr[24:20];
    assign is_op   = (opcode == OPC_OP);
    assign is_imm  = (opcode == OPC_OP_IMM);
    assign illegal = ~(is_op | is_imm);

    regfile_2r1w #(.NREG(NREG), .XLEN(XLEN)) u_rf (
        .clk        (clk),
        .rs1_addr_i (rs1),
        .rs1_data_o (rs1_val),
        .rs2_addr_i (rs2),
        .rs2_data_o (rs2_val),
        .wr_en_i    (wb_en),
        .wr_addr_i  (wb_rd),
        .wr_data_i  (wb_data)
    );

    logic [NREG-1:0] busy_q, busy_d, wb_mask, busy_eff;
    issue_t          dec, out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            hazard, accept;

    always_comb begin
        wb_mask = '0;
        if (wb_en) begin
            wb_mask[wb_rd] = 1'b1;
        end
    end

    // A register being written back this cycle is already readable through the bypass.
    assign busy_eff = busy_q & ~wb_mask;
    assign hazard   = ~illegal & (busy_eff[rs1] | (is_op & busy_eff[rs2]));
    assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        dec         = '0;
        dec.op      = ~illegal;
        dec.op_imm  = is_imm;
        dec.funct3  = f3;
        dec.funct7  = in_instr[31:25];
        dec.rd      = rd;
        dec.illegal = illegal;
        if (is_op) begin
            dec.a = rs1_val;
            dec.b = rs2_val;
        end else if (is_imm) begin
            dec.a = rs1_val;
            dec.b = is_shift(f3) ? XLEN'(rs2) : {{20{in_instr[31]}}, in_instr[31:20]};
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_d       = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        busy_d = busy_q & ~wb_mask;
        // A flushed entry never writes back, so its destination must be released here.
        if (flush && out_valid_q && !out_q.illegal && (out_q.rd != '0)) begin
            busy_d[out_q.rd] = 1'b0;
        end
        if (accept && !illegal && (rd != '0)) begin
            busy_d[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = out_q.op;
    assign out_op_imm  = out_q.op_imm;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random traffic against a behavioural model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic        out_op, out_op_imm, out_illegal;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_a, out_b, wb_data;
    logic [4:0]  out_rd, wb_rd;
    logic        wb_en, flush;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_op_imm(out_op_imm), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .out_illegal(out_illegal),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: architectural registers, pending-write set, and the issued entry.
    logic [31:0] rf [32];
    bit          pend [32];
    bit          m_valid;
    bit          m_op, m_imm, m_ill;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] src_val(input int r);
        if (r == 0) return 32'd0;
        if (wb_en && int'(wb_rd) == r) return wb_data;
        return rf[r];
    endfunction

    function automatic bit still_pending(input int r);
        return pend[r] && !(wb_en && int'(wb_rd) == r);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_imm = 0; m_ill = 0;
        m_f3 = 0; m_f7 = 0; m_a = 0; m_b = 0; m_rd = 0;
        for (int r = 0; r < 32; r++) pend[r] = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic step();
        int          rs1, rs2, rd, f3, imm;
        bit          is_r, is_i, legal, stall, exp_rdy, acc;
        logic [31:0] na, nb;
        @(negedge clk);
        rs1  = int'(in_instr[19:15]);
        rs2  = int'(in_instr[24:20]);
        rd   = int'(in_instr[11:7]);
        f3   = int'(in_instr[14:12]);
        is_r = (in_instr[6:0] == 7'h33);
        is_i = (in_instr[6:0] == 7'h13);
        legal = is_r || is_i;
        stall = legal && (still_pending(rs1) || (is_r && still_pending(rs2)));
        exp_rdy = (!m_valid || out_ready) && !stall && !flush;
        acc = in_valid && exp_rdy;

        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (m_valid) begin
            chk("out_op",      {31'd0, out_op},      {31'd0, m_op});
            chk("out_op_imm",  {31'd0, out_op_imm},  {31'd0, m_imm});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
            chk("out_funct3",  {29'd0, out_funct3},  {29'd0, m_f3});
            chk("out_funct7",  {25'd0, out_funct7},  {25'd0, m_f7});
            chk("out_a",       out_a,                m_a);
            chk("out_b",       out_b,                m_b);
            chk("out_rd",      {27'd0, out_rd},      {27'd0, m_rd});
        end

        na = legal ? src_val(rs1) : 32'd0;
        if (is_r) begin
            nb = src_val(rs2);
        end else if (is_i && (f3 == 1 || f3 == 5)) begin
            nb = rs2;
        end else if (is_i) begin
            imm = int'(in_instr[31:20]);
            if (imm >= 2048) imm -= 4096;
            nb = imm;
        end else begin
            nb = 32'd0;
        end

        @(posedge clk);
        if (wb_en && wb_rd != 0) begin
            rf[wb_rd]   = wb_data;
            pend[wb_rd] = 0;
        end
        if (flush && m_valid && !m_ill && m_rd != 0) pend[m_rd] = 0;
        if (acc && legal && rd != 0) pend[rd] = 1;
        if (flush) begin
            m_valid = 0;
        end else if (acc) begin
            m_valid = 1; m_op = legal; m_imm = is_i; m_ill = !legal;
            m_f3 = in_instr[14:12]; m_f7 = in_instr[31:25];
            m_a = na; m_b = nb; m_rd = in_instr[11:7];
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 0; wb_en = 0; flush = 0; out_ready = 1;
    endtask

    // Registers probed for pending writes through in_ready of "add x0, rN, x0".
    task automatic probe(input logic [4:0] r);
        idle();
        in_instr = enc_r(7'd0, 5'd0, r, 3'd0, 5'd0);
        step();
    endtask

    initial begin
        rst_n = 0; in_instr = 32'h0; wb_rd = 0; wb_data = 0;
        idle();
        model_reset();
        #2;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_op",    {31'd0, out_op},    32'd0);
        chk("rst out_a",     out_a,              32'd0);
        chk("rst out_b",     out_b,              32'd0);
        chk("rst out_rd",    {27'd0, out_rd},    32'd0);
        chk("rst out_illegal", {31'd0, out_illegal}, 32'd0);
        #20 rst_n = 1;
        @(posedge clk); #1;

        for (int r = 1; r < 32; r++) begin
            idle();
            wb_en = 1; wb_rd = 5'(r);
            wb_data = (r == 1) ? 32'd5 : (r == 2) ? 32'd7 : $urandom;
            step();
        end

        // Basic register-register op.
        idle(); in_valid = 1; in_instr = 32'h002081B3; step();
        idle(); in_instr = 32'h0;
        chk("add a", out_a, 32'd5);
        chk("add b", out_b, 32'd7);
        chk("add rd", {27'd0, out_rd}, 32'd3);
        probe(5'd3);

        // Immediates: sign-extended and shift forms.
        idle(); in_valid = 1; in_instr = 32'hFFF00213; step();
        chk("addi b", out_b, 32'hFFFFFFFF);
        chk("addi op_imm", {31'd0, out_op_imm}, 32'd1);
        idle(); in_valid = 1; in_instr = 32'h4030D293; step();
        chk("srai b", out_b, 32'd3);
        chk("srai funct7", {25'd0, out_funct7}, 32'h20);

        // RAW stall released by writeback with same-cycle bypass.
        idle(); in_valid = 1; in_instr = 32'h002081B3; step();
        in_instr = enc_r(7'd0, 5'd3, 5'd3, 3'd0, 5'd6);
        for (int i = 0; i < 3; i++) step();
        wb_en = 1; wb_rd = 5'd3; wb_data = 32'h12; step();
        idle();
        chk("bypass a", out_a, 32'h12);
        chk("bypass b", out_b, 32'h12);
        chk("bypass rd", {27'd0, out_rd}, 32'd6);

        // Backpressure hold, then drain one per cycle.
        idle(); out_ready = 0; in_valid = 1; in_instr = enc_i(12'd9, 5'd1, 3'd0, 5'd9);
        step();
        in_instr = enc_i(12'd10, 5'd2, 3'd0, 5'd10);
        for (int i = 0; i < 3; i++) step();
        out_ready = 1; step();
        in_instr = enc_i(12'd11, 5'd2, 3'd4, 5'd11); step();
        in_valid = 0; step(); step();

        // Same-edge issue and writeback of x7: pending must survive.
        idle(); in_valid = 1; in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd7); step();
        wb_en = 1; wb_rd = 5'd7; wb_data = 32'hABCD; step();
        probe(5'd7);
        chk("x7 still pending", {31'd0, in_ready}, 32'd0);

        // Illegal opcode and flush.
        idle(); in_valid = 1; in_instr = 32'h0000A183; step();
        chk("lw illegal", {31'd0, out_illegal}, 32'd1);
        chk("lw op", {31'd0, out_op}, 32'd0);
        probe(5'd3);
        idle(); in_valid = 1; in_instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd8); step();
        idle(); flush = 1; step();
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        probe(5'd8);

        // Random traffic over a small register window to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            int kind;
            logic [4:0] ra, rb, rdst;
            logic [2:0] f;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = ($urandom_range(0, 2) == 0);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rdst = 5'($urandom_range(0, 7));
            f = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                in_instr = enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, rb, ra, f, rdst);
            end else if (kind < 9) begin
                in_instr = enc_i(12'($urandom), ra, f, rdst);
            end else begin
                in_instr = $urandom;
                if (in_instr[6:0] == 7'h33 || in_instr[6:0] == 7'h13) in_instr[6:0] = 7'h23;
            end
            step();
        end

        // Asynchronous reset with an entry held in the output register.
        idle(); out_ready = 0; in_valid = 1; in_instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd12);
        for (int i = 0; i < 3; i++) step();
        #2 rst_n = 0;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst out_rd", {27'd0, out_rd}, 32'd0);
        model_reset();
        #1 rst_n = 1;
        probe(5'd12);
        probe(5'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
